qrf_pipo_channel: RTL and testbench

QRF_PIPO_CHANNEL -- requirements
Module: qrf_pipo_channel

---
 rtl/qrf_pipo_channel_pkg.sv | 27 ++
 rtl/qrf_pipo_channel_bank_ram.sv | 61 ++++++
 rtl/qrf_pipo_channel.sv | 98 +++++++++
 tb/tb_qrf_pipo_channel.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/qrf_pipo_channel_pkg.sv
// Shared definitions for the QRF ping-pong (PIPO) channel: default geometry
// and the encoding of the committed-bank count.
package qrf_pipo_channel_pkg;

    localparam int QRF_DATA_WIDTH = 32;
    localparam int QRF_ADDR_WIDTH = 4;
    localparam int QRF_DEPTH      = 16;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_HALF  = 2'd1,
        CNT_FULL  = 2'd2
    } count_t;

    // Occupancy after one accepted commit (up) or release (down).
    function automatic count_t count_step(input count_t cur, input logic up);
        count_t nxt;
        case (cur)
            CNT_EMPTY: nxt = up ? CNT_HALF : CNT_EMPTY;
            CNT_HALF:  nxt = up ? CNT_FULL : CNT_EMPTY;
            CNT_FULL:  nxt = up ? CNT_FULL : CNT_HALF;
            default:   nxt = CNT_EMPTY;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/qrf_pipo_channel_bank_ram.sv
// One PIPO bank: single write port and a registered read port. Addresses at
// or beyond DEPTH are dropped on write and read back as zero.
module pipo_bank_ram
    import qrf_pipo_channel_pkg::*;
#(
    parameter int DATA_WIDTH = QRF_DATA_WIDTH,
    parameter int ADDR_WIDTH = QRF_ADDR_WIDTH,
    parameter int DEPTH      = QRF_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] q
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic                  wr_ok_s;
    logic                  rd_ok_s;
    logic [DATA_WIDTH-1:0] q_r;

    // Range qualification of both ports.
    always_comb begin
        wr_ok_s = 1'b0;
        rd_ok_s = 1'b0;
        if ({1'b0, waddr} < DEPTH_L) begin
            wr_ok_s = we;
        end else begin
            wr_ok_s = 1'b0;
        end
        if ({1'b0, raddr} < DEPTH_L) begin
            rd_ok_s = 1'b1;
        end else begin
            rd_ok_s = 1'b0;
        end
    end

    // Storage array; contents intentionally survive reset.
    always_ff @(posedge clock) begin
        if (wr_ok_s) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, holds when not enabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_r <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            q_r <= rd_ok_s ? mem_r[raddr] : {DATA_WIDTH{1'b0}};
        end
    end

    assign q = q_r;

endmodule

// File: rtl/qrf_pipo_channel.sv
// Two-bank ping-pong channel between a Q/R producer and its consumer; the
// producer fills bank wr_sel while the consumer drains bank rd_sel.
module qrf_pipo_channel
    import qrf_pipo_channel_pkg::*;
#(
    parameter int DATA_WIDTH = QRF_DATA_WIDTH,
    parameter int ADDR_WIDTH = QRF_ADDR_WIDTH,
    parameter int DEPTH      = QRF_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic                  i_ce,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_d,
    input  logic                  i_write,
    output logic                  i_full_n,
    input  logic [ADDR_WIDTH-1:0] t_address,
    input  logic                  t_ce,
    output logic [DATA_WIDTH-1:0] t_q,
    input  logic                  t_read,
    output logic                  t_empty_n
);

    count_t count_r;
    count_t count_nxt_s;
    logic   wr_sel_r;
    logic   wr_sel_nxt_s;
    logic   rd_sel_r;
    logic   rd_sel_nxt_s;
    logic   q_sel_r;
    logic   commit_s;
    logic   release_s;
    logic   wr_en_s;
    logic [1:0]            bank_we_s;
    logic [1:0]            bank_re_s;
    logic [DATA_WIDTH-1:0] bank_q_s [2];

    assign i_full_n  = (count_r != CNT_FULL);
    assign t_empty_n = (count_r != CNT_EMPTY);

    // Handshake acceptance, next state and per-bank port enables.
    always_comb begin
        commit_s     = i_write & i_full_n;
        release_s    = t_read & t_empty_n;
        wr_en_s      = i_ce & i_we & i_full_n;
        count_nxt_s  = count_r;
        wr_sel_nxt_s = wr_sel_r ^ commit_s;
        rd_sel_nxt_s = rd_sel_r ^ release_s;
        case ({commit_s, release_s})
            2'b10:   count_nxt_s = count_step(count_r, 1'b1);
            2'b01:   count_nxt_s = count_step(count_r, 1'b0);
            default: count_nxt_s = count_r;
        endcase
        bank_we_s[0] = wr_en_s & ~wr_sel_r;
        bank_we_s[1] = wr_en_s &  wr_sel_r;
        bank_re_s[0] = t_ce & ~rd_sel_r;
        bank_re_s[1] = t_ce &  rd_sel_r;
    end

    // Selector and occupancy registers. q_sel_r remembers which bank fed
    // the last read so t_q holds even after rd_sel moves on.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r  <= CNT_EMPTY;
            wr_sel_r <= 1'b0;
            rd_sel_r <= 1'b0;
            q_sel_r  <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            wr_sel_r <= wr_sel_nxt_s;
            rd_sel_r <= rd_sel_nxt_s;
            if (t_ce) begin
                q_sel_r <= rd_sel_r;
            end
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_bank
        pipo_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (DEPTH)
        ) u_bank (
            .clock (clock),
            .reset (reset),
            .we    (bank_we_s[k]),
            .waddr (i_address),
            .wdata (i_d),
            .re    (bank_re_s[k]),
            .raddr (t_address),
            .q     (bank_q_s[k])
        );
    end

    assign t_q = bank_q_s[q_sel_r];

endmodule

// File: tb/tb_qrf_pipo_channel.sv
// Directed self-checking bench for qrf_pipo_channel: fill/commit/read,
// full and empty boundaries, simultaneous commit/release and async reset.
module tb_qrf_pipo_channel;

    logic        clock;
    logic        reset;
    logic [3:0]  i_address;
    logic        i_ce;
    logic        i_we;
    logic [31:0] i_d;
    logic        i_write;
    logic        i_full_n;
    logic [3:0]  t_address;
    logic        t_ce;
    logic [31:0] t_q;
    logic        t_read;
    logic        t_empty_n;

    int tests_run    = 0;
    int tests_failed = 0;

    qrf_pipo_channel dut (
        .clock     (clock),
        .reset     (reset),
        .i_address (i_address),
        .i_ce      (i_ce),
        .i_we      (i_we),
        .i_d       (i_d),
        .i_write   (i_write),
        .i_full_n  (i_full_n),
        .t_address (t_address),
        .t_ce      (t_ce),
        .t_q       (t_q),
        .t_read    (t_read),
        .t_empty_n (t_empty_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        i_ce = 1'b1; i_we = 1'b1; i_address = a; i_d = d;
        cyc();
        i_ce = 1'b0; i_we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        t_ce = 1'b1; t_address = a;
        cyc();
        t_ce = 1'b0;
    endtask

    task automatic pulse(input logic wr_commit, input logic rd_release);
        i_write = wr_commit; t_read = rd_release;
        cyc();
        i_write = 1'b0; t_read = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        i_address = 4'd0; i_ce = 1'b0; i_we = 1'b0; i_d = 32'd0; i_write = 1'b0;
        t_address = 4'd0; t_ce = 1'b0; t_read = 1'b0;
        #2;
        check_val("rst_full_n",  {31'd0, i_full_n},  32'd1);
        check_val("rst_empty_n", {31'd0, t_empty_n}, 32'd0);
        check_val("rst_t_q",     t_q,                32'd0);
        @(negedge clock);
        reset = 1'b1;
        cyc();

        // Fill bank 0 and commit it.
        for (int a = 0; a < 16; a++) wr(4'(a), 32'h100 + 32'(a));
        check_val("pre_commit_empty_n", {31'd0, t_empty_n}, 32'd0);
        pulse(1'b1, 1'b0);
        check_val("commit_empty_n", {31'd0, t_empty_n}, 32'd1);
        check_val("commit_full_n",  {31'd0, i_full_n},  32'd1);
        rd(4'd5);
        check_val("read_b0_a5", t_q, 32'h105);

        // Fill bank 1, commit -> full; further write/commit dropped.
        for (int a = 0; a < 16; a++) wr(4'(a), 32'h200 + 32'(a));
        pulse(1'b1, 1'b0);
        check_val("full_full_n",  {31'd0, i_full_n},  32'd0);
        check_val("full_empty_n", {31'd0, t_empty_n}, 32'd1);
        wr(4'd0, 32'hDEAD);
        pulse(1'b1, 1'b0);
        check_val("full_ignore_full_n", {31'd0, i_full_n}, 32'd0);
        rd(4'd0);
        check_val("full_b0_a0", t_q, 32'h100);
        rd(4'd3);
        check_val("full_b0_a3", t_q, 32'h103);

        // count=2 with commit+release together: release only.
        pulse(1'b1, 1'b1);
        check_val("c2_both_full_n",  {31'd0, i_full_n},  32'd1);
        check_val("c2_both_empty_n", {31'd0, t_empty_n}, 32'd1);
        rd(4'd0);
        check_val("c2_b1_a0", t_q, 32'h200);
        rd(4'd15);
        check_val("c2_b1_a15", t_q, 32'h20F);

        // Same address written in bank 0 while read from bank 1.
        i_ce = 1'b1; i_we = 1'b1; i_address = 4'd2; i_d = 32'h302;
        t_ce = 1'b1; t_address = 4'd2;
        cyc();
        i_ce = 1'b0; i_we = 1'b0; t_ce = 1'b0;
        check_val("wr_rd_same_addr", t_q, 32'h202);

        // count=1 with commit+release together: both selectors toggle.
        pulse(1'b1, 1'b1);
        check_val("c1_both_full_n",  {31'd0, i_full_n},  32'd1);
        check_val("c1_both_empty_n", {31'd0, t_empty_n}, 32'd1);
        rd(4'd2);
        check_val("c1_b0_a2", t_q, 32'h302);
        rd(4'd0);
        check_val("c1_b0_a0", t_q, 32'h100);

        // Reach count=2 again, then assert reset mid-cycle.
        wr(4'd1, 32'h411);
        pulse(1'b1, 1'b0);
        check_val("pre_rst_full_n", {31'd0, i_full_n}, 32'd0);
        check_val("t_q_hold", t_q, 32'h100);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_rst_full_n",  {31'd0, i_full_n},  32'd1);
        check_val("async_rst_empty_n", {31'd0, t_empty_n}, 32'd0);
        check_val("async_rst_t_q",     t_q,                32'd0);
        @(negedge clock);
        reset = 1'b1;
        cyc();

        // Release while empty is ignored; next commit is bank 0.
        pulse(1'b0, 1'b1);
        check_val("empty_rel_empty_n", {31'd0, t_empty_n}, 32'd0);
        check_val("empty_rel_full_n",  {31'd0, i_full_n},  32'd1);
        wr(4'd7, 32'h507);
        pulse(1'b1, 1'b0);
        check_val("post_rst_empty_n", {31'd0, t_empty_n}, 32'd1);
        rd(4'd7);
        check_val("post_rst_b0_a7", t_q, 32'h507);
        rd(4'd6);
        check_val("post_rst_b0_a6", t_q, 32'h106);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
